// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and instruction-memory write-port bundle for imem_loader
//
// Purpose: groups the boot byte stream (valid/ready handshake) and the
// fetch controller write/enable port into one interface.
// Signals:
//   byte_valid    stream byte available (source -> loader)
//   byte_data     stream byte, 8 bits (source -> loader)
//   byte_ready    loader accepts a byte (loader -> source)
//   cntlr_wr      one-cycle memory write strobe (loader -> fetch)
//   cntlr_waddr   word address of the write, ADDR_WIDTH bits
//   cntlr_wr_data instruction word, DATA_WIDTH bits
//   cntlr_rd      fetch enable, high only once a load has completed
// Modports: master = stream source / fetch side, slave = loader.

interface imem_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;
  logic                  cntlr_rd;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  cntlr_wr,
    input  cntlr_waddr,
    input  cntlr_wr_data,
    input  cntlr_rd
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output cntlr_wr,
    output cntlr_waddr,
    output cntlr_wr_data,
    output cntlr_rd
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream program loader into instruction memory
//
// Purpose: receives a 16-bit little-endian word count followed by
// little-endian 32-bit instruction words, writes each word into
// instruction memory through the fetch controller write port, then
// releases fetch by raising cntlr_rd.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, one
// trailing XOR checksum byte is verified before release.
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       single-cycle load request (honoured in IDLE/DONE/ERROR)
//   bus           imem_loader_if.slave: byte stream in, memory write port out
//   o_busy        load in progress
//   o_done        load completed successfully
//   o_error       length or checksum failure, sticky until start/reset
//   o_word_count  words written in the current load

module imem_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  imem_loader_if.slave      bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_WIDTH:0] o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // State entered after the final word (or after an empty header).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LP_AFTER_DATA = S_CHK;
`else
  localparam state_t LP_AFTER_DATA = S_DONE;
`endif

  // Largest legal word count: the whole memory.
  localparam logic [16:0] LP_MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next;

  logic [15:0]           r_len;
  logic [1:0]            r_byte_idx;
  logic [DATA_WIDTH-9:0] r_word;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rd;
  logic                  r_done;
  logic                  r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_chk;
`endif

  logic                  w_fire;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_start_ok;
  logic                  w_word_done;
  logic                  w_last_word;
  logic                  w_len_over;
  logic                  w_len_zero;
  logic [15:0]           w_len_hdr;
  logic [ADDR_WIDTH:0]   w_count_inc;

  assign w_fire      = bus.byte_valid && w_ready;
  assign w_count_inc = r_word_count + 1'b1;
  assign w_len_hdr   = {bus.byte_data, r_len[7:0]};
  assign w_len_over  = {1'b0, w_len_hdr} > LP_MAX_WORDS;
  assign w_len_zero  = (w_len_hdr == 16'd0);
  assign w_word_done = w_fire && (r_state == S_DATA) && (r_byte_idx == 2'd3);
  // The word being completed is the last one when the incremented count hits N.
  assign w_last_word = (16'(w_count_inc) == r_len);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_start_ok = 1'b1;
          w_next     = S_LEN0;
        end
      end
      S_LEN0: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.byte_valid) begin
          w_next = S_LEN1;
        end
      end
      S_LEN1: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.byte_valid) begin
          if (w_len_over) begin
            w_next = S_ERROR;
          end else if (w_len_zero) begin
            w_next = LP_AFTER_DATA;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_word_done && w_last_word) begin
          w_next = LP_AFTER_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (bus.byte_valid) begin
          w_next = (bus.byte_data == r_chk) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, word assembly, write port and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_len        <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_word_count <= '0;
      r_wr         <= 1'b0;
      r_waddr      <= '0;
      r_wr_data    <= '0;
      r_rd         <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_chk        <= '0;
`endif
    end else begin
      r_wr <= w_word_done;
      // Fetch is released only once no write is issued or still in flight.
      r_rd    <= (w_next == S_DONE) && !w_word_done && !r_wr;
      r_done  <= (w_next == S_DONE);
      r_error <= (w_next == S_ERROR);

      if (w_word_done) begin
        r_waddr      <= r_word_count[ADDR_WIDTH-1:0];
        r_wr_data    <= {bus.byte_data, r_word};
        r_word_count <= w_count_inc;
      end

      if (w_start_ok) begin
        r_len        <= '0;
        r_byte_idx   <= '0;
        r_word       <= '0;
        r_word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_chk        <= '0;
`endif
      end else if (w_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // The checksum byte itself is not folded into the running XOR.
        if (r_state != S_CHK) begin
          r_chk <= r_chk ^ bus.byte_data;
        end
`endif
        case (r_state)
          S_LEN0: r_len[7:0]  <= bus.byte_data;
          S_LEN1: r_len[15:8] <= bus.byte_data;
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_word[7:0]   <= bus.byte_data;
              2'd1:    r_word[15:8]  <= bus.byte_data;
              2'd2:    r_word[23:16] <= bus.byte_data;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready    = w_ready;
  assign bus.cntlr_wr      = r_wr;
  assign bus.cntlr_waddr   = r_waddr;
  assign bus.cntlr_wr_data = r_wr_data;
  assign bus.cntlr_rd      = r_rd;
  assign o_busy            = w_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_word_count      = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader

module tb_imem_loader;
  localparam int AW = 11;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [AW:0] word_count;

  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          exp_done;
  bit          exp_err;
  int          exp_wc;
  int          cyc = 0;
  int          last_wr_cyc = -100;
  int          rd_rise_cyc = -100;
  logic        rd_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (bus.cntlr_wr === 1'b1) begin
      last_wr_cyc = cyc;
      check("rd_during_wr", {31'b0, bus.cntlr_rd}, 32'd0);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_wr: addr 0x%0h data 0x%0h with no write expected",
                 bus.cntlr_waddr, bus.cntlr_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {21'b0, bus.cntlr_waddr}, {21'b0, e.addr});
        check("wr_data", bus.cntlr_wr_data, e.data);
      end
    end
    if (bus.cntlr_rd === 1'b1 && rd_prev !== 1'b1) rd_rise_cyc = cyc;
    rd_prev = bus.cntlr_rd;
  end

  // Reference model: serialise words into the byte protocol and predict
  // the writes and the final status.
  task automatic build_load(input bit bad_chk);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = words.size();
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      logic [31:0] wd;
      wd = words[i];
      for (int b = 0; b < 4; b++) stream.push_back(wd[8*b +: 8]);
      w.addr = i[AW-1:0];
      w.data = wd;
      exp_q.push_back(w);
    end
    x = 8'h00;
    foreach (stream[i]) x = x ^ stream[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(bad_chk ? (x ^ 8'h01) : x);
    exp_err  = bad_chk;
    exp_done = !bad_chk;
`else
    exp_err  = 1'b0;
    exp_done = 1'b1;
`endif
    exp_wc = n;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    while ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 50 cycles", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input int gap_pct);
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], gap_pct);
  endtask

  task automatic finish_check();
    repeat (4) @(negedge clk);
    check("done", {31'b0, done}, {31'b0, exp_done});
    check("error", {31'b0, error}, {31'b0, exp_err});
    check("cntlr_rd", {31'b0, bus.cntlr_rd}, {31'b0, exp_done});
    check("word_count", {20'b0, word_count}, exp_wc);
    check("busy_end", {31'b0, busy}, 32'd0);
    check("byte_ready_end", {31'b0, bus.byte_ready}, 32'd0);
    check("writes_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("rst_cntlr_wr", {31'b0, bus.cntlr_wr}, 32'd0);
    check("rst_cntlr_waddr", {21'b0, bus.cntlr_waddr}, 32'd0);
    check("rst_cntlr_wr_data", bus.cntlr_wr_data, 32'd0);
    check("rst_cntlr_rd", {31'b0, bus.cntlr_rd}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_word_count", {20'b0, word_count}, 32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed normal load at full rate.
    words = '{32'h12345678, 32'hDEADBEEF};
    build_load(1'b0);
    send_stream(0);
    finish_check();
    check("rd_rise_gap", rd_rise_cyc - last_wr_cyc, 32'd2);

    // Same stream with random valid gaps.
    words = '{32'h12345678, 32'hDEADBEEF};
    build_load(1'b0);
    send_stream(40);
    finish_check();

    // Empty load.
    words.delete();
    build_load(1'b0);
    send_stream(0);
    finish_check();

    // Length overflow: N = 0x0801.
    stream = '{8'h01, 8'h08};
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_wc   = 0;
    send_stream(0);
    finish_check();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum, then the correct stream.
    words = '{32'h12345678, 32'hDEADBEEF};
    build_load(1'b1);
    send_stream(0);
    finish_check();
    words = '{32'h12345678, 32'hDEADBEEF};
    build_load(1'b0);
    send_stream(0);
    finish_check();
`endif

    // Reset mid-load: partial word discarded, outputs at reset values.
    stream = '{8'h02, 8'h00, 8'h78, 8'h56};
    send_stream(0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    words = '{32'hCAFEF00D, 32'h0BADBEEF};
    build_load(1'b0);
    send_stream(20);
    finish_check();

    // Randomised loads.
    for (int t = 0; t < 6; t++) begin
      int n;
      words.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_load($urandom_range(0, 3) == 0);
      send_stream($urandom_range(0, 60));
      finish_check();
    end

    // Full memory: N = 2^ADDR_WIDTH.
    words.delete();
    for (int i = 0; i < (1 << AW); i++) words.push_back($urandom);
    build_load(1'b0);
    send_stream(0);
    finish_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the fetch stage. It accepts a byte stream carrying a 16-bit word count and little-endian instruction words, and writes each word into instruction memory through fetch's controller write port (`cntlr_wr`, `cntlr_waddr`, `cntlr_wr_data`). When the load completes it asserts `cntlr_rd`, releasing fetch to run the core. Optionally it verifies an XOR checksum before release.

## Interface
- `ADDR_WIDTH`, default 11: instruction memory word-address width (2048 words).
- `DATA_WIDTH`, default 32: instruction word width. Only 32 is supported.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `byte_valid`  in  1  byte available on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte. A byte transfers when `byte_valid && byte_ready` at a clock edge.
- `cntlr_wr`  out  1  one-cycle memory write strobe to fetch.
- `cntlr_waddr`  out  ADDR_WIDTH  word address of the write.
- `cntlr_wr_data`  out  DATA_WIDTH  instruction word.
- `cntlr_rd`  out  1  fetch enable; high only in DONE.
- `busy`  out  1  load in progress (LEN0, LEN1, DATA, CHK).
- `done`  out  1  load completed successfully.
- `error`  out  1  length or checksum failure. Sticky until `start` or reset.
- `word_count`  out  ADDR_WIDTH+1  number of words written in the current load.

## Operation
- States: IDLE, LEN0, LEN1, DATA, CHK (macro builds only), DONE, ERROR.
- IDLE: waits for `start`. Bytes presented in this state are not accepted.
- `start` → LEN0. It also clears `word_count`, the byte index, the checksum, `done` and `error`.
- LEN0: the accepted byte becomes N[7:0]. Next state is LEN1.
- LEN1: the accepted byte becomes N[15:8]. Transitions:
  - N > 2^ADDR_WIDTH → ERROR.
  - N == 0 → CHK if the macro is built in, otherwise DONE.
  - Any other N → DATA.
- DATA: each byte is placed into the word under assembly. Byte index 0 goes to [7:0], index 3 goes to [31:24].
- On acceptance of byte index 3, the completed word is written to address `word_count` and `word_count` increments.
- After word N is written, DATA exits to CHK if the macro is built in, otherwise to DONE.
- `word_count` never exceeds N, so the write address cannot wrap.
- DONE: `cntlr_rd` held high. `start` → LEN0, which drops `cntlr_rd`.
- ERROR: `cntlr_rd` held low and no writes are issued. `start` → LEN0.
- `start` in LEN0, LEN1, DATA or CHK is ignored.
- `byte_ready` = 1 in LEN0, LEN1, DATA and CHK; 0 elsewhere. The loader never stalls a byte mid-load.

## Timing
- Reset values: state IDLE, and all of the following are 0: `byte_ready`, `cntlr_wr`, `cntlr_waddr`, `cntlr_wr_data`, `cntlr_rd`, `busy`, `done`, `error`, `word_count`, byte index, checksum.
- Write latency: if byte index 3 is accepted at edge k, then `cntlr_wr`, `cntlr_waddr` and `cntlr_wr_data` are registered and valid for exactly the cycle after edge k. `cntlr_wr` is deasserted at edge k+1.
- Back-to-back bytes at full rate give at most one `cntlr_wr` per 4 cycles.
- `cntlr_rd` is registered as (state==DONE && !cntlr_wr). It therefore rises at least one cycle after the last `cntlr_wr` cycle and never overlaps it.
- `done` and `error` are registered and assert on the edge entering DONE or ERROR.
- `rst_n` low mid-load:
  - Return to IDLE on that edge.
  - The partial word is discarded and no further write occurs.
  - Words already written remain in memory.
- Gaps in `byte_valid` stall assembly with no effect on results.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - The checksum is the XOR of every accepted byte, including both length bytes.
  - After the last word, CHK accepts one checksum byte.
  - Byte equals the running XOR → DONE. Otherwise → ERROR, with `cntlr_rd` never asserted.
- Undefined: CHK state and checksum logic are absent. The loader goes from the last word, or from N==0, directly to DONE.

## Test plan
- Normal load, macro on, full rate:
  - Stimulus: `start`, then 02 00 78 56 34 12 EF BE AD DE 28.
  - Required: writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF; `word_count`=2; `done`=1; `cntlr_rd` rises one cycle after the second `cntlr_wr`.
- Same stream with random `byte_valid` gaps → identical writes and the same final state.
- Empty load: N=0 (00 00, checksum 00) → no `cntlr_wr`; `done`=1; `cntlr_rd`=1.
- Length overflow: header 01 08 (N=0x0801) with ADDR_WIDTH=11 → `error`=1 after the second byte; no `cntlr_wr`; `byte_ready`=0.
- Bad checksum: the normal-load stream ending in 29 → both writes occur; `error`=1; `cntlr_rd` stays 0. A following `start` with the correct stream → `done`=1.
- Reset mid-load: `rst_n` low after byte 02 00 78 56 → all outputs at reset values, no write. A new load then starts at addr 0.
